matrix_tile_writer: RTL



---
 rtl/matrix_tile_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_tile_writer.sv
// matrix_tile_writer
// Packs an 8-bit valid/ready byte stream little-endian into DATA_W-bit words
// and writes each word to a zero-wait-state single-port RAM slave port.
// A command (start, base_addr, byte_len) launches a transfer; busy/done
// report progress. A partial final word enables only its filled lanes.
// Optional feature: define MATRIX_TILE_WRITER_CHECKSUM_EN to add a 16-bit
// running sum of accepted bytes on output port 'checksum'.
module matrix_tile_writer #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 17,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      byte_len,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [LANE_W-1:0]   lane_idx_q, lane_idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LANES-1:0]    be_q, be_d;
  logic                in_ready_q, in_ready_d;
  logic                write_q, write_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
  logic [15:0]         csum_q, csum_d;
`endif

  logic                accept;

  // A byte transfers when the stream offers one while we advertise ready.
  assign accept = in_valid & in_ready_q;

  // Next-state, packing datapath and registered-output decode.
  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path leaves one
    // unassigned and no latch can be inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lane_idx_d  = lane_idx_q;
    data_d      = data_q;
    be_d        = be_q;
    busy_d      = busy_q;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = byte_len;
          lane_idx_d  = '0;
          data_d      = '0;
          be_d        = '0;
          busy_d      = 1'b1;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
          csum_d      = '0;
`endif
          state_d     = (byte_len == '0) ? S_DONE : S_FILL;
        end
      end

      S_FILL: begin
        // Partial words wait here for more bytes; they are never flushed early.
        if (accept) begin
          data_d[{lane_idx_q, 3'b000} +: 8] = in_data;
          be_d[lane_idx_q]                  = 1'b1;
          remaining_d                       = remaining_q - LEN_W'(1);
          lane_idx_d                        = lane_idx_q + LANE_W'(1);
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
          csum_d                            = csum_q + 16'(in_data);
`endif
          if ((lane_idx_q == LANE_W'(LANES - 1)) || (remaining_q == LEN_W'(1))) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // The word goes out this cycle; prepare an empty word for the next one.
        addr_d     = addr_q + ADDR_W'(1);
        data_d     = '0;
        be_d       = '0;
        lane_idx_d = '0;
        state_d    = (remaining_q == '0) ? S_DONE : S_FILL;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Control outputs are decoded from the next state and registered, so
    // in_ready never depends combinationally on in_valid.
    in_ready_d = (state_d == S_FILL);
    write_d    = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // State and datapath registers; all clear asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      data_q      <= '0;
      be_q        <= '0;
      in_ready_q  <= 1'b0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lane_idx_q  <= lane_idx_d;
      data_q      <= data_d;
      be_q        <= be_d;
      in_ready_q  <= in_ready_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = data_q;
  assign mem_chipselect = write_q;
  assign mem_write      = write_q;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef MATRIX_TILE_WRITER_CHECKSUM_EN
  assign checksum       = csum_q;
`endif

endmodule
